// File: rtl/mem_response_unit_if.sv
// mem_response_unit_if
//   Bundles the datapath request handshake and the RAM port of the memory
//   response unit so they travel as one port.
//
//   slave  : the response unit itself (consumes requests, drives hits and
//            the RAM strobes)
//   master : the environment (request unit/datapath plus the RAM model)
//
//   Requests : imemren, imemaddr, dmemren, dmemwen, dmemaddr, dmemstore
//   Responses: ihit, dhit, imemload, dmemload, merr
//   RAM side : ramren, ramwen, ramaddr, ramstore, ramload, ramready
interface mem_response_unit_if;
  logic        imemren;
  logic [31:0] imemaddr;
  logic        dmemren;
  logic        dmemwen;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramren;
  logic        ramwen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        merr;

  modport slave (
    input  imemren, imemaddr, dmemren, dmemwen, dmemaddr, dmemstore,
    input  ramload, ramready,
    output ihit, dhit, imemload, dmemload,
    output ramren, ramwen, ramaddr, ramstore, merr
  );

  modport master (
    output imemren, imemaddr, dmemren, dmemwen, dmemaddr, dmemstore,
    output ramload, ramready,
    input  ihit, dhit, imemload, dmemload,
    input  ramren, ramwen, ramaddr, ramstore, merr
  );
endinterface

// File: rtl/mem_response_unit.sv
// mem_response_unit
//   Memory-side responder between the request unit/datapath and a single
//   RAM port. Accepts one instruction or data access at a time (data wins
//   when both are requested), holds the RAM strobes stable for the whole
//   access, enforces a minimum of LAT cycles in the access state, and
//   returns a one-cycle ihit/dhit pulse with the load word.
//
//   Ports:
//     CLK   - clock, all state changes on the rising edge
//     nRST  - asynchronous active-low reset
//     bus   - mem_response_unit_if.slave (requests, hits, loads, RAM port,
//             merr)
//
//   Parameters:
//     LAT     - minimum cycles spent in an access state (1..15)
//     TIMEOUT - watchdog limit in cycles (only with the watchdog build)
//
//   Build option:
//     MEM_RESP_TIMEOUT_EN - when defined, a watchdog aborts an access that
//     has not completed within TIMEOUT cycles and pulses merr. When not
//     defined there is no watchdog and merr is tied low.
module mem_response_unit #(
  parameter int LAT     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               nRST,
  mem_response_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  generate
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("mem_response_unit: LAT must be in 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_response_unit: TIMEOUT must be at least 1");
    end
  endgenerate

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic [31:0] dload_q;
  logic [31:0] iload_q;
  logic        wdir_q;
  logic        ren_q;
  logic        wen_q;
  logic        dhit_q;
  logic        ihit_q;
  logic        in_acc;
  logic        req_held;
  logic        lat_ok;
  logic        start_d;
  logic        start_i;
  logic        done;
  logic        wd_expired;

  assign in_acc = (state == DACC) || (state == IACC);

  // The request that opened the access must still be present; losing it
  // aborts the access.
  assign req_held = (state == DACC) ? (bus.dmemren | bus.dmemwen) : bus.imemren;
  assign lat_ok   = (cnt >= LAT_M1);

  // Watchdog: counts cycles spent in the current access and flags the last
  // allowed cycle. A timeout is the only way to fall back to IDLE from an
  // access while the request is still held.
`ifdef MEM_RESP_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wdog;
  logic            tout;
  logic            merr_q;

  assign wd_expired = (wdog == WD_LAST);
  assign tout       = in_acc && req_held && (next_state == IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog   <= '0;
      merr_q <= 1'b0;
    end else begin
      merr_q <= tout;
      if (start_d || start_i) begin
        wdog <= '0;
      end else if (in_acc) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  assign bus.merr = merr_q;
`else
  assign wd_expired = 1'b0;
  assign bus.merr   = 1'b0;
`endif

  // Next-state decode. Data requests take priority in IDLE; in an access an
  // aborted request wins over completion, and completion wins over timeout.
  always_comb begin
    next_state = state;
    start_d    = 1'b0;
    start_i    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dmemren || bus.dmemwen) begin
          next_state = DACC;
          start_d    = 1'b1;
        end else if (bus.imemren) begin
          next_state = IACC;
          start_i    = 1'b1;
        end
      end
      DACC, IACC: begin
        if (!req_held) begin
          next_state = IDLE;
        end else if (bus.ramready && lat_ok) begin
          next_state = RESP;
          done       = 1'b1;
        end else if (wd_expired) begin
          next_state = IDLE;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Access context: address, store word and direction are latched when the
  // access is accepted; the latency counter restarts on every entry and
  // saturates so long stalls cannot wrap it below LAT-1.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wdir_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (start_d) begin
        addr_q  <= bus.dmemaddr;
        store_q <= bus.dmemstore;
        wdir_q  <= bus.dmemwen;
        cnt     <= '0;
      end else if (start_i) begin
        addr_q  <= bus.imemaddr;
        wdir_q  <= 1'b0;
        cnt     <= '0;
      end else if (in_acc && cnt != 4'd15) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // RAM strobes are flops so they stay glitch-free and constant for the
  // whole access; they drop on the edge that leaves the access state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ren_q <= 1'b0;
      wen_q <= 1'b0;
    end else if (start_d) begin
      ren_q <= ~bus.dmemwen;
      wen_q <= bus.dmemwen;
    end else if (start_i) begin
      ren_q <= 1'b1;
      wen_q <= 1'b0;
    end else if (next_state != DACC && next_state != IACC) begin
      ren_q <= 1'b0;
      wen_q <= 1'b0;
    end
  end

  // Hit pulses and load capture on the completing edge. The hit flops are
  // only set by a completion, so they are high for the single RESP cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dhit_q  <= 1'b0;
      ihit_q  <= 1'b0;
      dload_q <= '0;
      iload_q <= '0;
    end else begin
      dhit_q <= done && (state == DACC);
      ihit_q <= done && (state == IACC);
      if (done && (state == DACC) && !wdir_q) begin
        dload_q <= bus.ramload;
      end
      if (done && (state == IACC)) begin
        iload_q <= bus.ramload;
      end
    end
  end

  assign bus.ramren   = ren_q;
  assign bus.ramwen   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.dhit     = dhit_q;
  assign bus.ihit     = ihit_q;
  assign bus.dmemload = dload_q;
  assign bus.imemload = iload_q;

endmodule

// File: tb/tb_mem_response_unit.sv
// tb_mem_response_unit
//   Self-checking bench for mem_response_unit with LAT=2, TIMEOUT=64.
//   Inputs change on the falling edge and outputs are checked on the falling
//   edge. Each access is driven from an expected schedule: the completing
//   access cycle is the first cycle index j >= LAT-1 in which ramready is
//   high, and the hit appears in the cycle after it.
module tb_mem_response_unit;

  localparam int LAT     = 2;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic        dren;
    logic        dwen;
    logic        iren;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rload;
    int          delay;
    int          expJ;
    logic        expData;
    logic        expRen;
    logic        expWen;
  } vec_t;

  logic clk;
  logic nrst;
  int   compared;
  int   mismatched;
  logic [31:0] expDload;
  logic [31:0] expIload;

  mem_response_unit_if bus ();

  mem_response_unit #(
    .LAT     (LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic dren, input logic dwen, input logic iren,
                               input logic [31:0] daddr, input logic [31:0] dstore,
                               input logic [31:0] iaddr);
    bus.dmemren   = dren;
    bus.dmemwen   = dwen;
    bus.imemren   = iren;
    bus.dmemaddr  = daddr;
    bus.dmemstore = dstore;
    bus.imemaddr  = iaddr;
  endtask

  // Completing access cycle from the ready pattern.
  function automatic int firstReady(input logic [31:0] rdy);
    for (int j = LAT - 1; j < 32; j++) begin
      if (rdy[j]) return j;
    end
    return 31;
  endfunction

  // Runs one access whose request is already applied at a falling edge in
  // IDLE. rdy[j] is ramready during access cycle j; expJ is the cycle that
  // should complete. Afterwards the selected requests are dropped during the
  // hit cycle and the following IDLE cycle is checked.
  task automatic runAccess(input logic dataSide, input logic expRen, input logic expWen,
                           input logic [31:0] expAddr, input logic [31:0] expStore,
                           input logic [31:0] load, input logic [31:0] rdy, input int expJ,
                           input logic dropD, input logic dropI);
    @(posedge clk);
    for (int j = 0; j <= expJ; j++) begin
      @(negedge clk);
      checkOutput("acc_ramren", {31'b0, bus.ramren}, {31'b0, expRen});
      checkOutput("acc_ramwen", {31'b0, bus.ramwen}, {31'b0, expWen});
      checkOutput("acc_ramaddr", bus.ramaddr, expAddr);
      if (expWen) checkOutput("acc_ramstore", bus.ramstore, expStore);
      checkOutput("acc_nohit", {30'b0, bus.dhit, bus.ihit}, 32'd0);
      bus.ramready = rdy[j];
      bus.ramload  = rdy[j] ? load : $urandom();
      @(posedge clk);
    end
    @(negedge clk);
    if (expRen) begin
      if (dataSide) expDload = load;
      else          expIload = load;
    end
    checkOutput("resp_dhit", {31'b0, bus.dhit}, {31'b0, dataSide});
    checkOutput("resp_ihit", {31'b0, bus.ihit}, {31'b0, ~dataSide});
    checkOutput("resp_strobes", {30'b0, bus.ramren, bus.ramwen}, 32'd0);
    checkOutput("resp_dmemload", bus.dmemload, expDload);
    checkOutput("resp_imemload", bus.imemload, expIload);
    checkOutput("resp_merr", {31'b0, bus.merr}, 32'd0);
    bus.ramready = 1'b0;
    bus.ramload  = $urandom();
    if (dropD) begin
      bus.dmemren = 1'b0;
      bus.dmemwen = 1'b0;
    end
    if (dropI) bus.imemren = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_nohit", {30'b0, bus.dhit, bus.ihit}, 32'd0);
    checkOutput("idle_strobes", {30'b0, bus.ramren, bus.ramwen}, 32'd0);
    checkOutput("idle_dmemload", bus.dmemload, expDload);
    checkOutput("idle_imemload", bus.imemload, expIload);
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] rdy;
    logic [31:0] rdy2;
    logic [31:0] a;
    logic [31:0] a2;
    logic [31:0] st;
    logic [31:0] ld;
    logic [31:0] ld2;
    int kind;

    compared   = 0;
    mismatched = 0;
    expDload   = '0;
    expIload   = '0;

    vecs[0] = '{dren:1'b1, dwen:1'b0, iren:1'b0, addr:32'h0000_0100, store:32'h0,
                rload:32'hDEAD_BEEF, delay:0, expJ:1, expData:1'b1, expRen:1'b1, expWen:1'b0};
    vecs[1] = '{dren:1'b0, dwen:1'b1, iren:1'b0, addr:32'h0000_0200, store:32'h1234_5678,
                rload:32'h5555_AAAA, delay:0, expJ:1, expData:1'b1, expRen:1'b0, expWen:1'b1};
    vecs[2] = '{dren:1'b0, dwen:1'b0, iren:1'b1, addr:32'h0000_0040, store:32'h0,
                rload:32'h8C01_0004, delay:0, expJ:1, expData:1'b0, expRen:1'b1, expWen:1'b0};
    vecs[3] = '{dren:1'b1, dwen:1'b1, iren:1'b0, addr:32'h0000_0300, store:32'hAABB_CCDD,
                rload:32'h0F0F_0F0F, delay:0, expJ:1, expData:1'b1, expRen:1'b0, expWen:1'b1};
    vecs[4] = '{dren:1'b1, dwen:1'b0, iren:1'b0, addr:32'h0000_0104, store:32'h0,
                rload:32'hCAFE_F00D, delay:10, expJ:10, expData:1'b1, expRen:1'b1, expWen:1'b0};
    vecs[5] = '{dren:1'b0, dwen:1'b0, iren:1'b1, addr:32'h0000_0044, store:32'h0,
                rload:32'h2108_0001, delay:1, expJ:1, expData:1'b0, expRen:1'b1, expWen:1'b0};
    vecs[6] = '{dren:1'b0, dwen:1'b0, iren:1'b1, addr:32'h0000_0048, store:32'h0,
                rload:32'h3C1F_0002, delay:3, expJ:3, expData:1'b0, expRen:1'b1, expWen:1'b0};

    // Reset state
    nrst         = 1'b0;
    bus.ramready = 1'b0;
    bus.ramload  = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hits", {30'b0, bus.dhit, bus.ihit}, 32'd0);
    checkOutput("rst_strobes", {30'b0, bus.ramren, bus.ramwen}, 32'd0);
    checkOutput("rst_ramaddr", bus.ramaddr, 32'd0);
    checkOutput("rst_ramstore", bus.ramstore, 32'd0);
    checkOutput("rst_dmemload", bus.dmemload, 32'd0);
    checkOutput("rst_imemload", bus.imemload, 32'd0);
    checkOutput("rst_merr", {31'b0, bus.merr}, 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].iren) applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, vecs[i].addr);
      else applyStimulus(vecs[i].dren, vecs[i].dwen, 1'b0, vecs[i].addr, vecs[i].store, '0);
      rdy = 32'hFFFF_FFFF << vecs[i].delay;
      runAccess(vecs[i].expData, vecs[i].expRen, vecs[i].expWen, vecs[i].addr,
                vecs[i].store, vecs[i].rload, rdy, vecs[i].expJ, 1'b1, 1'b1);
    end

    // Simultaneous data and instruction: data first, instruction follows
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0600, '0, 32'h0000_0800);
    runAccess(1'b1, 1'b1, 1'b0, 32'h0000_0600, '0, 32'h1111_2222, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    runAccess(1'b0, 1'b1, 1'b0, 32'h0000_0800, '0, 32'h3333_4444, 32'hFFFF_FFFF, 1, 1'b1, 1'b1);

    // Abort: data request dropped in the second DACC cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0500, '0, '0);
    bus.ramready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ren_c1", {31'b0, bus.ramren}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ren_c2", {31'b0, bus.ramren}, 32'd1);
    checkOutput("abort_addr_c2", bus.ramaddr, 32'h0000_0500);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ren_off", {31'b0, bus.ramren}, 32'd0);
    checkOutput("abort_nohit", {30'b0, bus.dhit, bus.ihit}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_nohit_late", {30'b0, bus.dhit, bus.ihit}, 32'd0);
    checkOutput("abort_dmemload", bus.dmemload, expDload);

    // Asynchronous reset in the middle of an instruction access
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 32'h0000_07F0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_ren_before", {31'b0, bus.ramren}, 32'd1);
    checkOutput("rstmid_addr_before", bus.ramaddr, 32'h0000_07F0);
    #2 nrst = 1'b0;
    #1;
    checkOutput("rstmid_ren", {31'b0, bus.ramren}, 32'd0);
    checkOutput("rstmid_addr", bus.ramaddr, 32'd0);
    checkOutput("rstmid_hits", {30'b0, bus.dhit, bus.ihit}, 32'd0);
    checkOutput("rstmid_dmemload", bus.dmemload, 32'd0);
    checkOutput("rstmid_imemload", bus.imemload, 32'd0);
    expDload = '0;
    expIload = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_after_ren", {31'b0, bus.ramren}, 32'd0);
    checkOutput("rstmid_after_hits", {30'b0, bus.dhit, bus.ihit}, 32'd0);

`ifdef MEM_RESP_TIMEOUT_EN
    // Watchdog: ramready never arrives
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0900, '0, '0);
    bus.ramready = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      checkOutput("wd_merr_low", {31'b0, bus.merr}, 32'd0);
      checkOutput("wd_ren_held", {31'b0, bus.ramren}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("wd_merr_pulse", {31'b0, bus.merr}, 32'd1);
    checkOutput("wd_nohit", {30'b0, bus.dhit, bus.ihit}, 32'd0);
    checkOutput("wd_ren_off", {31'b0, bus.ramren}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wd_merr_end", {31'b0, bus.merr}, 32'd0);
`endif

    // Randomized accesses against the schedule model
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      a    = $urandom();
      a2   = $urandom();
      st   = $urandom();
      ld   = $urandom();
      ld2  = $urandom();
      rdy  = ($urandom() & ($urandom_range(0, 1) != 0 ? $urandom() : 32'hFFFF_FFFF)) | 32'hFFFF_F000;
      rdy2 = $urandom() | 32'hFFFF_F000;
      case (kind)
        0: begin
          applyStimulus(1'b1, 1'b0, 1'b0, a, st, '0);
          runAccess(1'b1, 1'b1, 1'b0, a, st, ld, rdy, firstReady(rdy), 1'b1, 1'b1);
        end
        1: begin
          applyStimulus(1'b0, 1'b1, 1'b0, a, st, '0);
          runAccess(1'b1, 1'b0, 1'b1, a, st, ld, rdy, firstReady(rdy), 1'b1, 1'b1);
        end
        2: begin
          applyStimulus(1'b1, 1'b1, 1'b0, a, st, '0);
          runAccess(1'b1, 1'b0, 1'b1, a, st, ld, rdy, firstReady(rdy), 1'b1, 1'b1);
        end
        3: begin
          applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, a);
          runAccess(1'b0, 1'b1, 1'b0, a, '0, ld, rdy, firstReady(rdy), 1'b1, 1'b1);
        end
        default: begin
          applyStimulus(1'b1, 1'b0, 1'b1, a, st, a2);
          runAccess(1'b1, 1'b1, 1'b0, a, st, ld, rdy, firstReady(rdy), 1'b1, 1'b0);
          runAccess(1'b0, 1'b1, 1'b0, a2, '0, ld2, rdy2, firstReady(rdy2), 1'b1, 1'b1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
